// File: rtl/wb_pkg.sv
// Shared types for the register-file write-back path.
package wb_pkg;
  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// In-order FIFO of write-back entries; exposes every slot in age order
// (index 0 = head/oldest) so the top level can search pending writes.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push,
  input  logic                          pop,
  input  wb_entry_t                     wdata,
  output wb_entry_t                     head,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(DEPTH):0]        count,
  output wb_entry_t [DEPTH-1:0]         ents,
  output logic [DEPTH-1:0]              ent_vld
);
  localparam int AW = $clog2(DEPTH);

  wb_entry_t         mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; occupancy alone decides which slots are live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

  always_comb begin
    ents    = '0;
    ent_vld = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ents[i]    = mem[rd_ptr + AW'(i)];
      ent_vld[i] = ((AW+1)'(i) < count);
    end
  end
endmodule

// File: rtl/regfile_wb_queue.sv
// Write-back queue feeding the register file's single write port, with
// LSU-priority arbitration, x0 filtering and youngest-first forwarding.
module regfile_wb_queue
  import wb_pkg::REG_AW, wb_pkg::wb_entry_t;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   lsu_valid,
  output logic                   lsu_ready,
  input  logic [REG_AW-1:0]      lsu_rd,
  input  logic [XLEN-1:0]        lsu_data,
  input  logic                   alu_valid,
  output logic                   alu_ready,
  input  logic [REG_AW-1:0]      alu_rd,
  input  logic [XLEN-1:0]        alu_data,
  output logic                   rf_we,
  output logic [REG_AW-1:0]      rf_rd,
  output logic [XLEN-1:0]        rf_indata,
  input  logic [REG_AW-1:0]      fwd_rs1,
  input  logic [REG_AW-1:0]      fwd_rs2,
  output logic                   fwd_hit1,
  output logic                   fwd_hit2,
  output logic [XLEN-1:0]        fwd_data1,
  output logic [XLEN-1:0]        fwd_data2,
  output logic [$clog2(DEPTH):0] count
);
  logic                  full;
  logic                  empty;
  logic                  lsu_acc;
  logic                  alu_acc;
  logic                  push;
  logic                  pop;
  wb_entry_t             wdata;
  wb_entry_t             head;
  wb_entry_t [DEPTH-1:0] ents;
  logic [DEPTH-1:0]      ent_vld;

  // Ready depends only on registered occupancy and lsu_valid, never on the drain.
  assign lsu_ready = !full;
  assign alu_ready = !full && !lsu_valid;
  assign lsu_acc   = lsu_valid && lsu_ready;
  assign alu_acc   = alu_valid && alu_ready;

  always_comb begin
    wdata = '0;
    push  = 1'b0;
    if (lsu_acc) begin
      wdata = '{rd: lsu_rd, data: lsu_data};
      push  = (lsu_rd != '0);
    end else if (alu_acc) begin
      wdata = '{rd: alu_rd, data: alu_data};
      push  = (alu_rd != '0);
    end
  end

  assign pop = !empty;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .pop     (pop),
    .wdata   (wdata),
    .head    (head),
    .full    (full),
    .empty   (empty),
    .count   (count),
    .ents    (ents),
    .ent_vld (ent_vld)
  );

  // Output stage: register-file write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we     <= 1'b0;
      rf_rd     <= '0;
      rf_indata <= '0;
    end else if (pop) begin
      rf_we     <= 1'b1;
      rf_rd     <= head.rd;
      rf_indata <= head.data;
    end else begin
      rf_we     <= 1'b0;
    end
  end

  logic [1:0][REG_AW-1:0] rs;
  logic [1:0]             hit;
  logic [1:0][XLEN-1:0]   dat;

  assign rs = {fwd_rs2, fwd_rs1};

  // Scan oldest to youngest so the last match wins.
  always_comb begin
    hit = '0;
    dat = '0;
    for (int p = 0; p < 2; p++) begin
      if (rs[p] != '0) begin
        if (rf_we && (rf_rd == rs[p])) begin
          hit[p] = 1'b1;
          dat[p] = rf_indata;
        end
        for (int i = 0; i < DEPTH; i++) begin
          if (ent_vld[i] && (ents[i].rd == rs[p])) begin
            hit[p] = 1'b1;
            dat[p] = ents[i].data;
          end
        end
      end
    end
  end

  assign fwd_hit1  = hit[0];
  assign fwd_hit2  = hit[1];
  assign fwd_data1 = dat[0];
  assign fwd_data2 = dat[1];
endmodule
